// File: rtl/conv_window_packer.sv
// Packs a serial stream of DATA_WIDTH-bit elements into N = D*F*F element windows,
// element k at window[DATA_WIDTH*k +: DATA_WIDTH]. Optional framing check: LAST_CHECK_EN.
module conv_window_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int F          = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_last,
  output logic                              win_valid,
  input  logic                              win_ready,
  output logic [0:D*F*F*DATA_WIDTH-1]       window,
  output logic                              err
);

  localparam int N  = D * F * F;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0]           idx;
  logic                    col_full;
  logic [0:N*DATA_WIDTH-1] col;
  logic                    accept;
  logic                    xfer;
  logic                    at_last;
  logic                    early_last;

  // in_ready depends only on registered state, never on win_ready
  assign in_ready = !col_full;
  assign accept   = in_valid && in_ready;
  assign xfer     = col_full && (!win_valid || win_ready);
  assign at_last  = (idx == LAST_IDX);

`ifdef LAST_CHECK_EN
  assign early_last = in_last && !at_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (accept && (in_last != at_last)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = in_last;
  assign early_last  = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      col_full  <= 1'b0;
      col       <= '0;
      window    <= '0;
      win_valid <= 1'b0;
    end else begin
      if (accept) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (idx == IW'(k)) col[DATA_WIDTH*k +: DATA_WIDTH] <= in_data;
        end
        // an early last drops the partial window so framing restarts at element 0
        if (early_last) begin
          idx <= '0;
        end else if (at_last) begin
          idx      <= '0;
          col_full <= 1'b1;
        end else begin
          idx <= idx + IW'(1);
        end
      end
      if (xfer) begin
        window    <= col;
        win_valid <= 1'b1;
        col_full  <= 1'b0;
      end else if (win_valid && win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_packer.sv
// Bench for conv_window_packer: N=4 and N=25 instances, vector table, directed
// sequences and a queue-based reference model under random stimulus.
module tb_conv_window_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_last;
  logic        win_ready;
  logic [15:0] in_data;

  logic        rdy4, wv4, err4;
  logic [0:63] win4;
  logic        rdy25, wv25, err25;
  logic [0:399] win25;

  always #5 clk = ~clk;

  conv_window_packer #(.DATA_WIDTH(16), .D(1), .F(2)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data), .in_last(in_last), .win_valid(wv4),
    .win_ready(win_ready), .window(win4), .err(err4)
  );

  conv_window_packer #(.DATA_WIDTH(16), .D(1), .F(5)) u25 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy25),
    .in_data(in_data), .in_last(in_last), .win_valid(wv25),
    .win_ready(win_ready), .window(win25), .err(err25)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [15:0] d, logic l, logic wr);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    win_ready = wr;
    cyc();
  endtask

  // hold one beat until the selected instance accepts it
  task automatic send(bit big, logic [15:0] d, logic l);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 50 && !done; i++) begin
      done = big ? rdy25 : rdy4;
      cyc();
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("rst_valid", {63'd0, wv4}, 64'd0);
    chk("rst_window", win4, 64'd0);
    chk("rst_ready", {63'd0, rdy4}, 64'd1);
    reset = 1'b0;
  endtask

  // reference model: elements collect into groups of 4, a completed group
  // waits in one slot until the single output slot is free or being taken
  logic [15:0] col_q[$];
  logic [63:0] full_q[$];
  logic [63:0] out_q[$];

  task automatic model_edge(logic v, logic [15:0] d, logic wr);
    bit acc, take, move;
    logic [63:0] w;
    acc  = v && (full_q.size() == 0);
    take = (out_q.size() != 0) && wr;
    move = (full_q.size() != 0) && ((out_q.size() == 0) || wr);
    if (take) void'(out_q.pop_front());
    if (move) out_q.push_back(full_q.pop_front());
    if (acc) begin
      col_q.push_back(d);
      if (col_q.size() == 4) begin
        w = '0;
        foreach (col_q[k]) w = {w[47:0], col_q[k]};
        full_q.push_back(w);
        col_q.delete();
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        wr;
    logic        ex_ready;
    logic        ex_wv;
    logic [63:0] ex_win;
  } vec_t;

  localparam logic [63:0] W1 = 64'h3C00_4000_4200_4400;

  vec_t tbl[17];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic        v, wr, l;
    logic [15:0] d;
    int          taken;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; win_ready = 1'b0;

    // back-to-back window, then the same window with input gaps after a reset
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[1]  = '{1'b0, 1'b1, 16'h3C00, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[2]  = '{1'b0, 1'b1, 16'h4000, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[3]  = '{1'b0, 1'b1, 16'h4200, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[4]  = '{1'b0, 1'b1, 16'h4400, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, W1};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, W1};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[8]  = '{1'b0, 1'b1, 16'h3C00, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[9]  = '{1'b0, 1'b0, 16'hDEAD, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[10] = '{1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[11] = '{1'b0, 1'b1, 16'h4000, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[12] = '{1'b0, 1'b1, 16'h4200, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[13] = '{1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0};
    tbl[14] = '{1'b0, 1'b1, 16'h4400, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, W1};
    tbl[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, W1};

    for (int i = 0; i < 17; i++) begin
      reset = tbl[i].rst;
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].wr);
      chk($sformatf("tbl%0d_ready", i), {63'd0, rdy4}, {63'd0, tbl[i].ex_ready});
      chk($sformatf("tbl%0d_valid", i), {63'd0, wv4}, {63'd0, tbl[i].ex_wv});
      chk($sformatf("tbl%0d_window", i), win4, tbl[i].ex_win);
      chk($sformatf("tbl%0d_err", i), {63'd0, err4}, 64'd0);
    end
    reset = 1'b0;

    // backpressure: A held while B fills, then one-cycle replace with no bubble
    do_reset();
    win_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(1'b0, 16'(k + 1), k == 3);
    for (int k = 0; k < 4; k++) send(1'b0, 16'(k + 17), k == 3);
    chk("bp_ready_low", {63'd0, rdy4}, 64'd0);
    chk("bp_valid", {63'd0, wv4}, 64'd1);
    chk("bp_window_a", win4, 64'h0001_0002_0003_0004);
    for (int k = 0; k < 3; k++) drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("bp_hold_ready", {63'd0, rdy4}, 64'd0);
    chk("bp_hold_window", win4, 64'h0001_0002_0003_0004);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    chk("bp_window_b", win4, 64'h0011_0012_0013_0014);
    chk("bp_valid_nobubble", {63'd0, wv4}, 64'd1);
    chk("bp_ready_back", {63'd0, rdy4}, 64'd1);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    chk("bp_drained", {63'd0, wv4}, 64'd0);

    // mid-window reset leaves no residue
    win_ready = 1'b1;
    send(1'b0, 16'hAAAA, 1'b0);
    send(1'b0, 16'hBBBB, 1'b0);
    reset = 1'b1;
    drive(1'b1, 16'hCCCC, 1'b0, 1'b1);
    chk("mr_during_valid", {63'd0, wv4}, 64'd0);
    chk("mr_during_window", win4, 64'd0);
    chk("mr_during_err", {63'd0, err4}, 64'd0);
    reset = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    chk("mr_after_valid", {63'd0, wv4}, 64'd0);
    chk("mr_after_window", win4, 64'd0);
    for (int k = 0; k < 4; k++) send(1'b0, 16'((k + 1) * 16'h1111), k == 3);
    cyc();
    chk("mr_valid", {63'd0, wv4}, 64'd1);
    chk("mr_window", win4, 64'h1111_2222_3333_4444);

`ifdef LAST_CHECK_EN
    do_reset();
    win_ready = 1'b1;
    send(1'b0, 16'h0001, 1'b0);
    send(1'b0, 16'h0002, 1'b0);
    send(1'b0, 16'h0003, 1'b1);
    chk("early_err", {63'd0, err4}, 64'd1);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    chk("early_no_window", {63'd0, wv4}, 64'd0);
    for (int k = 0; k < 4; k++) send(1'b0, 16'(k + 5), k == 3);
    cyc();
    chk("early_resync_valid", {63'd0, wv4}, 64'd1);
    chk("early_resync_window", win4, 64'h0005_0006_0007_0008);
    chk("early_err_sticky", {63'd0, err4}, 64'd1);
    do_reset();
    chk("missing_err_cleared", {63'd0, err4}, 64'd0);
    win_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(1'b0, 16'(k + 9), 1'b0);
    chk("missing_err", {63'd0, err4}, 64'd1);
    cyc();
    chk("missing_valid", {63'd0, wv4}, 64'd1);
    chk("missing_window", win4, 64'h0009_000A_000B_000C);
`else
    do_reset();
    win_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(1'b0, 16'(k + 9), k == 1);
    cyc();
    chk("nolast_valid", {63'd0, wv4}, 64'd1);
    chk("nolast_window", win4, 64'h0009_000A_000B_000C);
    chk("nolast_err", {63'd0, err4}, 64'd0);
`endif

    // default geometry, N=25
    do_reset();
    win_ready = 1'b1;
    for (int k = 0; k < 25; k++) send(1'b1, 16'(k + 1), k == 24);
    cyc();
    chk("n25_valid", {63'd0, wv25}, 64'd1);
    chk("n25_first", {48'd0, win25[0:15]}, 64'h0001);
    for (int k = 0; k < 25; k++)
      chk($sformatf("n25_elem%0d", k), {48'd0, win25[16*k +: 16]}, 64'(k + 1));
    chk("n25_err", {63'd0, err25}, 64'd0);

    // random traffic against the reference model
    do_reset();
    col_q.delete(); full_q.delete(); out_q.delete();
    taken = 0;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      d  = 16'($urandom);
      wr = ($urandom_range(0, 9) < 6);
      l  = (col_q.size() == 3);
      if (wv4 && wr) taken++;
      model_edge(v, d, wr);
      drive(v, d, l, wr);
      chk("rnd_ready", {63'd0, rdy4}, {63'd0, full_q.size() == 0});
      chk("rnd_valid", {63'd0, wv4}, {63'd0, out_q.size() != 0});
      if (out_q.size() != 0) chk("rnd_window", win4, out_q[0]);
    end
    chk("rnd_err", {63'd0, err4}, 64'd0);
    if (taken < 10) chk("rnd_throughput", 64'(taken), 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
